ahb_lite_arbiter: RTL and testbench
===================================

AHB_LITE_ARBITER -- requirements
Module: ahb_lite_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the address width of the requester ports and haddr.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width of wdata, rdata, hwdata and hrdata; legal values are 32 and 64.
REQ-003 hclk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 hreset  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 req_valid  in  2  SHALL be the per-requester request valid (bit i = requester i).
REQ-006 req_ready  out  2  SHALL be the per-requester accept strobe.
REQ-007 req_addr  in  2*ADDR_WIDTH  SHALL carry the packed request addresses, with requester i at slice i.
REQ-008 req_write  in  2  SHALL carry the per-requester direction: 1 = write.
REQ-009 req_size  in  6  SHALL carry the packed per-requester HSIZE codes, 3 bits each.
REQ-010 req_wdata  in  2*DATA_WIDTH  SHALL carry the packed per-requester write data.
REQ-011 rsp_valid  out  2  SHALL pulse to the owning requester on completion.
REQ-012 rsp_rdata  out  DATA_WIDTH  SHALL carry read data, shared and valid with rsp_valid.
REQ-013 rsp_err  out  1  SHALL flag an error response, shared and valid with rsp_valid.
REQ-014 err_count  out  16  SHALL count error completions.
REQ-015 haddr, htrans[1:0], hwrite, hsize[3], hburst[3], hprot[4], hsel, hwdata  out  SHALL form the AHB-Lite master request; widths as for AHB-Lite.
REQ-016 hrdata, hready, hresp  in  SHALL be the AHB-Lite slave response; hresp is 1 bit, with 0 = OKAY and 1 = ERROR.

Function
REQ-017 The FSM SHALL have the states IDLE, ADDR, DATA and REJ.
REQ-018 In IDLE, req_ready SHALL be asserted combinationally for exactly the granted requester whose req_valid is high; all other req_ready bits SHALL be 0.
- Outside IDLE, req_ready = 2'b00.
REQ-019 Arbitration SHALL be round-robin using a last-grant pointer.
- On contention, grant goes to the requester not granted last.
- After reset the pointer favours requester 0.
- The pointer updates only on acceptance.
REQ-020 On acceptance, the arbiter SHALL latch the owner, addr, write, size and wdata.
- A request is legal when size <= log2(DATA_WIDTH/8) and addr is aligned to 2^size bytes; a legal request moves the FSM to ADDR.
- An illegal request moves the FSM to REJ.
REQ-021 In ADDR, the arbiter SHALL drive the following:
- htrans = NONSEQ (2'b10) and hsel = 1;
- haddr, hwrite and hsize from the latched request;
- hburst = SINGLE (3'b000) and hprot = 4'b0011.
- The FSM stays in ADDR while hready = 0 and moves to DATA on hready = 1.
REQ-022 In DATA, the arbiter SHALL drive the following:
- htrans = IDLE and hsel = 0;
- hwdata = latched wdata for writes, 0 for reads.
- The FSM waits while hready = 0.
- On hready = 1 it captures hrdata (reads) and hresp, and returns to IDLE.
REQ-023 In the cycle after the DATA-phase hready = 1 completion, rsp_valid[owner] SHALL be 1 for exactly one cycle, together with the following:
- rsp_err = the captured hresp;
- rsp_rdata = the captured hrdata for reads, 0 for writes.
REQ-024 An AHB two-cycle ERROR response (hresp = 1 with hready = 0, then hresp = 1 with hready = 1) SHALL complete as a single response with rsp_err = 1.
REQ-025 REJ SHALL last one cycle with no AHB activity and return to IDLE; the following cycle gives rsp_valid[owner] = 1, rsp_err = 1 and rsp_rdata = 0.
REQ-026 err_count SHALL increment by 1 on every response with rsp_err = 1 and saturate at 16'hFFFF.
REQ-027 Minimum latency with zero wait states SHALL be as follows:
- accept at T, ADDR at T+1, DATA at T+2, rsp_valid at T+3;
- a new accept is allowed at T+3.
REQ-028 Outside ADDR, haddr, hwrite, hsize SHALL be 0 and hburst SHALL be SINGLE; outside DATA, hwdata SHALL be 0.
REQ-029 The arbiter SHALL never issue BUSY or SEQ, and SHALL never assert more than one rsp_valid bit per cycle.
REQ-030 Changes on req_* after acceptance SHALL NOT affect the transfer in flight.

Reset
REQ-031 While hreset = 1 at a rising hclk edge, the arbiter SHALL set:
- FSM = IDLE, pointer to favour requester 0, err_count = 0;
- all latched fields = 0;
- rsp_valid = 0, rsp_err = 0, rsp_rdata = 0;
- htrans = IDLE, hsel = 0, haddr = 0, hwdata = 0, hburst = SINGLE, hprot = 4'b0011.
- req_ready = 0 while hreset = 1.
REQ-032 Reset asserted mid-transfer (ADDR or DATA) SHALL abandon the transfer without issuing any rsp_valid.

Verification
REQ-033 Single read: requester 0 reads addr 0x100, size 2, hready = 1 and hrdata = 0xDEADBEEF -> NONSEQ at T+1, rsp_valid = 2'b01 at T+3, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-034 Contention: both requesters valid continuously with writes -> grants alternate 0,1,0,1; hwdata matches each owner's wdata; rsp_valid alternates 01, 10.
REQ-035 Wait states: hready held low 3 cycles in DATA for a requester 1 write of 0x55AA55AA -> hwdata stable for 4 cycles; rsp_valid = 2'b10 one cycle after hready returns high.
REQ-036 Errors: an AHB two-cycle ERROR, then a misaligned request (addr 0x102, size 2) -> both complete with rsp_err = 1; REJ drives no NONSEQ; err_count = 2.
REQ-037 Reset in DATA: hreset asserted while hready = 0 -> next cycle all outputs at reset values, no rsp_valid; the next request is granted to requester 0 on a tie.

Source files
------------

// File: rtl/ahb_lite_arbiter.sv
// Two-requester round-robin front end onto a single AHB-Lite master port.
// Each accepted request becomes one SINGLE NONSEQ transfer or an immediate rejection.
module ahb_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]              req_write,
  input  logic [5:0]              req_size,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   haddr,
  output logic [1:0]              htrans,
  output logic                    hwrite,
  output logic [2:0]              hsize,
  output logic [2:0]              hburst,
  output logic [3:0]              hprot,
  output logic                    hsel,
  output logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH-1:0]   hrdata,
  input  logic                    hready,
  input  logic                    hresp
);

  // state | meaning
  // IDLE  | waiting for a request; req_ready offered to the granted requester
  // ADDR  | NONSEQ address phase, held until hready
  // DATA  | data phase, held until hready; response captured on completion
  // REJ   | illegal request swallowed for one cycle, error response follows
  typedef enum logic [1:0] {IDLE, ADDR, DATA, REJ} state_t;

  localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

  state_t                  state_q, state_d;
  logic                    last_q;
  logic                    owner_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [1:0]              rsp_valid_q;
  logic                    rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [15:0]             err_count_q;

  logic                    gnt;
  logic                    accept;
  logic                    legal;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [2:0]              sel_size;
  logic [2:0]              align_mask;
  logic                    resp_fire;
  logic                    resp_err;

  always_comb begin
    gnt = 1'b0;
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
  end

  assign accept    = (state_q == IDLE) && !hreset && (req_valid != 2'b00);
  assign req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign sel_addr  = gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_size  = gnt ? req_size[5:3] : req_size[2:0];

  always_comb begin
    align_mask = 3'b111;
    case (sel_size)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign legal = (sel_size <= MAX_SIZE) && ((sel_addr[2:0] & align_mask) == 3'b000);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = legal ? ADDR : REJ;
      ADDR:    if (hready) state_d = DATA;
      DATA:    if (hready) state_d = IDLE;
      REJ:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // hresp is only sampled with hready, so a two-cycle ERROR completes once
  assign resp_fire = ((state_q == DATA) && hready) || (state_q == REJ);
  assign resp_err  = (state_q == REJ) || hresp;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      wdata_q     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_count_q <= 16'h0000;
    end else begin
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      if (accept) begin
        last_q  <= gnt;
        owner_q <= gnt;
        addr_q  <= sel_addr;
        write_q <= gnt ? req_write[1] : req_write[0];
        size_q  <= sel_size;
        wdata_q <= gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      end
      if (resp_fire) begin
        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
        rsp_err_q   <= resp_err;
        rsp_rdata_q <= ((state_q == DATA) && !write_q) ? hrdata : '0;
        if (resp_err && (err_count_q != 16'hFFFF))
          err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err_count = err_count_q;

  assign htrans = (state_q == ADDR) ? 2'b10 : 2'b00;
  assign hsel   = (state_q == ADDR);
  assign haddr  = (state_q == ADDR) ? addr_q : '0;
  assign hwrite = (state_q == ADDR) ? write_q : 1'b0;
  assign hsize  = (state_q == ADDR) ? size_q : 3'd0;
  assign hburst = 3'b000;
  assign hprot  = 4'b0011;
  assign hwdata = ((state_q == DATA) && write_q) ? wdata_q : '0;

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Self-checking bench: directed vector table, reset corner sequences and randomized
// transactions checked against a transaction-level arbitration/legality model.
module tb_ahb_lite_arbiter;

  logic        hclk, hreset;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [5:0]  req_size;
  logic [31:0] rsp_rdata, haddr, hwdata, hrdata;
  logic        rsp_err, hwrite, hsel, hready, hresp;
  logic [15:0] err_count;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  int checks = 0;
  int failures = 0;
  int last_m;
  logic [15:0] err_m;

  ahb_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .hclk(hclk), .hreset(hreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_count(err_count),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hsel(hsel), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  wr;
    logic [31:0] a0, a1;
    logic [2:0]  s0, s1;
    logic [31:0] d0, d1;
    int          aw, dw;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_htrans"}, 64'(htrans), 64'd0);
    chk({tag, "_hsel"},   64'(hsel),   64'd0);
    chk({tag, "_haddr"},  64'(haddr),  64'd0);
    chk({tag, "_hwdata"}, 64'(hwdata), 64'd0);
    chk({tag, "_hburst"}, 64'(hburst), 64'd0);
    chk({tag, "_hprot"},  64'(hprot),  64'd3);
  endtask

  // One complete transaction; entered with the DUT in IDLE, returns in the response cycle.
  task automatic txn(input vec_t t);
    int          g;
    logic [31:0] a, d;
    logic [2:0]  s;
    logic        w, legal;
    g = (t.v == 2'b11) ? (1 - last_m) : (t.v[1] ? 1 : 0);
    a = g ? t.a1 : t.a0;
    d = g ? t.d1 : t.d0;
    s = g ? t.s1 : t.s0;
    w = t.wr[g];
    legal = (s <= 3'd2) && ((a % (32'd1 << s)) == 32'd0);
    req_valid = t.v;
    req_write = t.wr;
    req_addr  = {t.a1, t.a0};
    req_size  = {t.s1, t.s0};
    req_wdata = {t.d1, t.d0};
    hready = 1'b1;
    hresp  = 1'b0;
    #2;
    chk("accept_ready", 64'(req_ready), g ? 64'd2 : 64'd1);
    chk("accept_htrans", 64'(htrans), 64'd0);
    nxt();
    last_m = g;
    req_valid = 2'b00;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_write = 2'($urandom);
    req_size  = 6'($urandom);
    if (!legal) begin
      #2;
      chk("rej_htrans", 64'(htrans), 64'd0);
      chk("rej_hsel", 64'(hsel), 64'd0);
      chk("rej_rsp_valid", 64'(rsp_valid), 64'd0);
      nxt();
    end else begin
      for (int i = 0; i <= t.aw; i++) begin
        hready = (i == t.aw);
        hresp  = 1'b0;
        #2;
        chk("addr_htrans", 64'(htrans), 64'd2);
        chk("addr_hsel",   64'(hsel),   64'd1);
        chk("addr_haddr",  64'(haddr),  64'(a));
        chk("addr_hwrite", 64'(hwrite), 64'(w));
        chk("addr_hsize",  64'(hsize),  64'(s));
        chk("addr_ready",  64'(req_ready), 64'd0);
        nxt();
      end
      for (int i = 0; i <= t.dw; i++) begin
        hready = (i == t.dw);
        hresp  = t.err && (i >= t.dw - 1);
        hrdata = (i == t.dw) ? t.rd : $urandom;
        #2;
        chk("data_hwdata", 64'(hwdata), w ? 64'(d) : 64'd0);
        chk("data_htrans", 64'(htrans), 64'd0);
        chk("data_haddr",  64'(haddr),  64'd0);
        chk("data_rsp_valid", 64'(rsp_valid), 64'd0);
        nxt();
      end
    end
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = $urandom;
    if ((!legal || t.err) && err_m != 16'hFFFF) err_m = err_m + 16'd1;
    #2;
    chk("rsp_valid", 64'(rsp_valid), g ? 64'd2 : 64'd1);
    chk("rsp_err",   64'(rsp_err),   legal ? 64'(t.err) : 64'd1);
    chk("rsp_rdata", 64'(rsp_rdata), (legal && !w) ? 64'(t.rd) : 64'd0);
    chk("err_count", 64'(err_count), 64'(err_m));
  endtask

  initial begin
    vec_t r;
    logic [2:0] mask;
    // v, wr, a0, a1, s0, s1, d0, d1, aw, dw, err, rd
    vecs[0] = '{2'b01, 2'b00, 32'h100, 32'h0,   3'd2, 3'd2, 32'h0, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{2'b11, 2'b11, 32'h200, 32'h300, 3'd2, 3'd2, 32'h11110000, 32'h22220000, 0, 0, 1'b0, 32'h0};
    vecs[2] = '{2'b11, 2'b11, 32'h204, 32'h304, 3'd2, 3'd2, 32'h11110001, 32'h22220001, 0, 0, 1'b0, 32'h0};
    vecs[3] = '{2'b11, 2'b11, 32'h208, 32'h308, 3'd2, 3'd2, 32'h11110002, 32'h22220002, 1, 0, 1'b0, 32'h0};
    vecs[4] = '{2'b11, 2'b11, 32'h20C, 32'h30C, 3'd2, 3'd2, 32'h11110003, 32'h22220003, 0, 1, 1'b0, 32'h0};
    vecs[5] = '{2'b10, 2'b10, 32'h0,   32'h40,  3'd2, 3'd2, 32'h0, 32'h55AA55AA, 0, 3, 1'b0, 32'h0};
    vecs[6] = '{2'b01, 2'b00, 32'h80,  32'h0,   3'd2, 3'd2, 32'h0, 32'h0, 0, 1, 1'b1, 32'h12345678};
    vecs[7] = '{2'b01, 2'b00, 32'h102, 32'h0,   3'd2, 3'd2, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0};
    vecs[8] = '{2'b10, 2'b10, 32'h0,   32'h0,   3'd0, 3'd3, 32'h0, 32'hCAFE, 0, 0, 1'b0, 32'h0};
    vecs[9] = '{2'b01, 2'b01, 32'h2,   32'h0,   3'd1, 3'd0, 32'hBEEF, 32'h0, 2, 0, 1'b0, 32'h0};

    hreset = 1'b1;
    req_valid = 2'b11; req_write = 2'b00; req_addr = '0; req_size = '0; req_wdata = '0;
    hrdata = '0; hready = 1'b1; hresp = 1'b0;
    last_m = 1; err_m = 16'd0;
    nxt(); nxt();
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk_idle_bus("rst");
    req_valid = 2'b00;
    hreset = 1'b0;
    nxt();

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i]);
      if (i == 7) chk("err_count_two", 64'(err_count), 64'd2);
    end

    // reset while the data phase is stalled
    r = '{2'b01, 2'b01, 32'h10, 32'h0, 3'd2, 3'd2, 32'hA5A5A5A5, 32'h0, 0, 0, 1'b0, 32'h0};
    req_valid = r.v; req_write = r.wr; req_addr = {r.a1, r.a0};
    req_size = {r.s1, r.s0}; req_wdata = {r.d1, r.d0};
    #2;
    chk("mid_accept", 64'(req_ready), 64'd1);
    nxt();
    req_valid = 2'b00; hready = 1'b1;
    nxt();
    hready = 1'b0;
    #2;
    chk("mid_hwdata", 64'(hwdata), 64'hA5A5A5A5);
    hreset = 1'b1;
    req_valid = 2'b11;
    nxt();
    #2;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_rsp",   64'(rsp_valid), 64'd0);
    chk("mid_rst_err",   64'(err_count), 64'd0);
    chk_idle_bus("mid_rst");
    last_m = 1; err_m = 16'd0;
    hreset = 1'b0; hready = 1'b1; req_valid = 2'b00;
    nxt();
    #2;
    chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
    r = '{2'b11, 2'b00, 32'h20, 32'h24, 3'd2, 3'd2, 32'h0, 32'h0, 0, 0, 1'b0, 32'h600D};
    txn(r);

    for (int n = 0; n < 150; n++) begin
      r.v  = 2'($urandom_range(1, 3));
      r.wr = 2'($urandom);
      r.a0 = $urandom; r.a1 = $urandom;
      r.s0 = 3'($urandom_range(0, 3)); r.s1 = 3'($urandom_range(0, 3));
      mask = (r.s0 == 0) ? 3'b000 : (r.s0 == 1) ? 3'b001 : 3'b011;
      if ($urandom_range(0, 3) != 0) r.a0[2:0] = r.a0[2:0] & ~mask;
      mask = (r.s1 == 0) ? 3'b000 : (r.s1 == 1) ? 3'b001 : 3'b011;
      if ($urandom_range(0, 3) != 0) r.a1[2:0] = r.a1[2:0] & ~mask;
      r.d0 = $urandom; r.d1 = $urandom;
      r.aw = $urandom_range(0, 2); r.dw = $urandom_range(0, 2);
      r.err = ($urandom_range(0, 5) == 0);
      r.rd = $urandom;
      txn(r);
    end

    nxt();
    #2;
    chk("final_rsp_idle", 64'(rsp_valid), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
